mux_scan_nto1: RTL and testbench

Parametrised N-channel, W-bit multiplexer with a registered output and two operating modes. In manual mode a host-loaded select is held. In scan mode an internal counter steps through every channel, dwelling a fixed number of cycles on each. The block feeds the display and measurement paths that previously used a fixed 4-to-1 combinational mux, and adds a coherent channel tag, a valid strobe and a wrap pulse.

---
 rtl/mux_scan_pkg.sv | 15 +
 rtl/mux_scan_next.sv | 30 +++
 rtl/mux_scan_nto1.sv | 123 ++++++++++++
 tb/tb_mux_scan_nto1.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the scanning N-to-1 mux: FSM state encoding and channel-index width helper.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  // Channel index width; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_next.sv
// Combinational finder for the next enabled channel, searching circularly from ch+1.
// Only used when MUX_SCAN_MASK_EN is defined.
module mux_scan_next
  import mux_scan_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = ch_w(4)
) (
  input  logic [SW-1:0] ch,
  input  logic [N-1:0]  ch_mask,
  output logic [SW-1:0] next_ch,
  output logic          found,
  output logic          wrapped
);

  // Walk from the farthest candidate back to ch+1 so the nearest enabled one wins.
  always_comb begin
    next_ch = ch;
    found   = 1'b0;
    wrapped = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (ch_mask[(int'(ch) + k) % N]) begin
        found   = 1'b1;
        next_ch = SW'((int'(ch) + k) % N);
        wrapped = (int'(ch) + k) >= N;
      end
    end
  end

endmodule

// File: rtl/mux_scan_nto1.sv
// N-channel W-bit mux with registered output, manual select and dwell-timed scan mode.
// Optional channel mask under `MUX_SCAN_MASK_EN`.
module mux_scan_nto1
  import mux_scan_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  W     = 1,
  parameter int  DWELL = 4,
  localparam int SW    = ch_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_bus,
  input  logic [SW-1:0]  sel,
  input  logic           load,
  input  logic           mode,
`ifdef MUX_SCAN_MASK_EN
  input  logic [N-1:0]   ch_mask,
`endif
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  output logic           out_wrap
);

  localparam int            DW    = $clog2(DWELL + 1);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

  state_t        r_state;
  logic [SW-1:0] r_ch;
  logic [DW-1:0] r_dwell;
  logic          r_wrap_pend;

  logic [SW-1:0] w_sel;
  logic [SW-1:0] w_adv_ch;
  logic [SW-1:0] w_first_ch;
  logic          w_adv_wrap;
  logic          w_scan_live;

  generate
    if (N == (1 << SW)) begin : g_noclamp
      assign w_sel = sel;
    end else begin : g_clamp
      assign w_sel = (sel > LAST) ? LAST : sel;
    end
  endgenerate

`ifdef MUX_SCAN_MASK_EN
  logic w_adv_found;
  logic w_adv_wrapped;

  mux_scan_next #(.N(N), .SW(SW)) u_next (
    .ch      (r_ch),
    .ch_mask (ch_mask),
    .next_ch (w_adv_ch),
    .found   (w_adv_found),
    .wrapped (w_adv_wrapped)
  );

  assign w_adv_wrap  = w_adv_found & w_adv_wrapped;
  assign w_scan_live = |ch_mask;

  // Lowest enabled channel is where a scan starts; 0 when nothing is enabled.
  always_comb begin
    w_first_ch = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ch_mask[i]) w_first_ch = SW'(i);
    end
  end
`else
  assign w_adv_ch    = (r_ch == LAST) ? '0 : r_ch + 1'b1;
  assign w_adv_wrap  = (r_ch == LAST);
  assign w_first_ch  = '0;
  assign w_scan_live = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ch        <= '0;
      r_dwell     <= '0;
      r_wrap_pend <= 1'b0;
      out         <= '0;
      out_ch      <= '0;
      out_valid   <= 1'b0;
      out_wrap    <= 1'b0;
    end else begin
      r_wrap_pend <= 1'b0;
      case (r_state)
        ST_IDLE, ST_MANUAL: begin
          if (mode) begin
            r_state <= ST_SCAN;
            r_ch    <= w_first_ch;
            r_dwell <= '0;
          end else if (load) begin
            r_state <= ST_MANUAL;
            r_ch    <= w_sel;
          end
        end
        ST_SCAN: begin
          if (!mode) begin
            r_state <= ST_MANUAL;
            if (load) r_ch <= w_sel;
          end else if (r_dwell == DLAST) begin
            r_dwell     <= '0;
            r_ch        <= w_adv_ch;
            r_wrap_pend <= w_adv_wrap;
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // Data, tag and wrap all come from the same ch snapshot so they stay coherent.
      out       <= in_bus[r_ch*W +: W];
      out_ch    <= r_ch;
      out_valid <= (r_state != ST_IDLE) && !((r_state == ST_SCAN) && !w_scan_live);
      out_wrap  <= r_wrap_pend;
    end
  end

endmodule

// File: tb/tb_mux_scan_nto1.sv
// Bench for mux_scan_nto1 (N=4, W=1, DWELL=2): directed sequences plus randomized run vs. a rule-level model.
module tb_mux_scan_nto1;

  localparam int N     = 4;
  localparam int DWELL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_bus;
  logic [1:0] sel;
  logic       load;
  logic       mode;
  logic [3:0] mask;
  logic [0:0] out;
  logic [1:0] out_ch;
  logic       out_valid;
  logic       out_wrap;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: spec rules on plain ints.
  int m_st, m_ch, m_dw, m_wp;
  int e_out, e_ch, e_vld, e_wrap;

  always #5 clk = ~clk;

  mux_scan_nto1 #(.N(N), .W(1), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bus    (in_bus),
    .sel       (sel),
    .load      (load),
    .mode      (mode),
`ifdef MUX_SCAN_MASK_EN
    .ch_mask   (mask),
`endif
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_wrap  (out_wrap)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] eff_mask();
`ifdef MUX_SCAN_MASK_EN
    return mask;
`else
    return 4'hF;
`endif
  endfunction

  // Nearest enabled channel after c going round the ring, -1 if none.
  function automatic int next_en(input int c, input logic [3:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(c + k) % N]) return (c + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] m;
    int n;
    m = eff_mask();
    if (rst) begin
      m_st = 0; m_ch = 0; m_dw = 0; m_wp = 0;
      e_out = 0; e_ch = 0; e_vld = 0; e_wrap = 0;
    end else begin
      e_out  = int'(in_bus[m_ch]);
      e_ch   = m_ch;
      e_vld  = (m_st != 0 && !(m_st == 2 && m == 4'h0)) ? 1 : 0;
      e_wrap = m_wp;
      m_wp   = 0;
      if (m_st != 2) begin
        if (mode) begin
          n = next_en(N - 1, m);
          m_st = 2; m_ch = (n < 0) ? 0 : n; m_dw = 0;
        end else if (load) begin
          m_st = 1; m_ch = int'(sel);
        end
      end else if (!mode) begin
        m_st = 1;
        if (load) m_ch = int'(sel);
      end else if (m_dw == DWELL - 1) begin
        m_dw = 0;
        n = next_en(m_ch, m);
        if (n >= 0) begin
          m_wp = (n <= m_ch) ? 1 : 0;
          m_ch = n;
        end
      end else begin
        m_dw++;
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_out"},  int'(out),       e_out);
    chk({tag, "_ch"},   int'(out_ch),    e_ch);
    chk({tag, "_vld"},  int'(out_valid), e_vld);
    chk({tag, "_wrap"}, int'(out_wrap),  e_wrap);
  endtask

  initial begin
    int man_sel[4]  = '{1, 2, 3, 0};
    int man_out[4]  = '{1, 0, 1, 0};
    int scan_ch[9]  = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int scan_out[9] = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
    bit seen;

    rst = 1'b1; mode = 1'b0; load = 1'b0; sel = '0; in_bus = 4'b1010; mask = 4'hF;
    @(negedge clk);
    step(); step();
    chk("rst_out", int'(out), 0);
    chk("rst_ch", int'(out_ch), 0);
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_wrap", int'(out_wrap), 0);
    rst = 1'b0;
    step(); step();
    chk("idle_vld", int'(out_valid), 0);
    chk("idle_ch", int'(out_ch), 0);

    // Manual loads on consecutive cycles.
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(man_sel[i]);
      step();
      if (i > 0) begin
        chk("man_ch", int'(out_ch), man_sel[i-1]);
        chk("man_out", int'(out), man_out[i-1]);
        chk("man_vld", int'(out_valid), 1);
      end
    end
    load = 1'b0;
    step();
    chk("man_ch", int'(out_ch), 0);
    chk("man_out", int'(out), 0);

    // Scan entry and one full revolution.
    mode = 1'b1;
    step();
    for (int i = 0; i < 9; i++) begin
      step();
      chk("scan_ch", int'(out_ch), scan_ch[i]);
      chk("scan_out", int'(out), scan_out[i]);
      chk("scan_vld", int'(out_valid), 1);
      chk("scan_wrap", int'(out_wrap), (i == 8) ? 1 : 0);
    end

    // Drop to manual while channel 2 is showing.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (out_ch == 2'd2) seen = 1'b1;
    end
    chk("scan_reach2", int'(seen), 1);
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ch", int'(out_ch), 2);
      chk("hold_vld", int'(out_valid), 1);
    end
    load = 1'b1; sel = 2'd3;
    step();
    load = 1'b0;
    step();
    chk("reload_ch", int'(out_ch), 3);
    chk("reload_out", int'(out), 1);

    // Reset mid-scan.
    mode = 1'b1;
    step(); step(); step(); step();
    rst = 1'b1; mode = 1'b0;
    step();
    chk("mrst_out", int'(out), 0);
    chk("mrst_ch", int'(out_ch), 0);
    chk("mrst_vld", int'(out_valid), 0);
    chk("mrst_wrap", int'(out_wrap), 0);
    rst = 1'b0;
    step(); step();
    chk("mrst_idle_vld", int'(out_valid), 0);

`ifdef MUX_SCAN_MASK_EN
    begin
      int mk_ch[5]   = '{1, 1, 3, 3, 1};
      int mk_wrap[5] = '{0, 0, 0, 0, 1};
      mask = 4'b1010; mode = 1'b1;
      step();
      for (int i = 0; i < 5; i++) begin
        step();
        chk("mask_ch", int'(out_ch), mk_ch[i]);
        chk("mask_wrap", int'(out_wrap), mk_wrap[i]);
      end
      mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        step();
        chk("mask0_vld", int'(out_valid), 0);
        chk("mask0_ch", int'(out_ch), 1);
      end
      mask = 4'hF; mode = 1'b0;
    end
`endif

    // Randomized run against the model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      load   = ($urandom_range(0, 3) == 0);
      sel    = 2'($urandom_range(0, 3));
      in_bus = 4'($urandom);
`ifdef MUX_SCAN_MASK_EN
      if ($urandom_range(0, 9) == 0) mask = 4'($urandom);
`endif
      step();
      chk_model("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
